// File: rtl/ti_sif_pkg.sv
// Shared types and helpers for the SIF receive slice: FSM state encoding
// and the frame-length function used to size the bit counter.
package ti_sif_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_WDATA,
      ST_RDATA,
      ST_WAIT_DESEL
   } sif_state_e;

   // Total number of serial bits in one frame: R/W flag, address, data.
   function automatic int unsigned sif_frame_len(input int unsigned rw_bits,
                                                 input int unsigned addr_bits,
                                                 input int unsigned data_bits);
      return rw_bits + addr_bits + data_bits;
   endfunction

endpackage

// File: rtl/ti_sif_sync.sv
// Multi-stage synchronizer for one asynchronous SIF pin. It provides the
// synchronized level plus registered one-cycle rise/fall flags that are
// aligned with that level.
module ti_sif_sync #(
   parameter int unsigned P_STAGES  = 2,
   parameter logic        P_RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_arst_n,
   input  logic i_d,
   output logic o_lvl,
   output logic o_rise,
   output logic o_fall
);

   logic [P_STAGES-1:0] sync_q;

   // Synchronizer chain, one extra level stage and registered edge flags.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         sync_q <= {P_STAGES{P_RST_VAL}};
         o_lvl  <= P_RST_VAL;
         o_rise <= 1'b0;
         o_fall <= 1'b0;
      end else begin
         sync_q <= {sync_q[P_STAGES-2:0], i_d};
         o_lvl  <= sync_q[P_STAGES-1];
         o_rise <= sync_q[P_STAGES-1] & ~o_lvl;
         o_fall <= ~sync_q[P_STAGES-1] & o_lvl;
      end
   end

endmodule

// File: rtl/ti_sif_rx.sv
// SIF slave receiver: decodes serial frames (R/W flag, address, data,
// MSB first) into register-write strobes. Define TI_SIF_RX_RD_EN to enable
// register reads with serial read-data return on o_sdout.
module ti_sif_rx
   import ti_sif_pkg::*;
#(
   parameter int unsigned P_SIF_ADDR_BITS  = 8,
   parameter int unsigned P_SIF_DATA_BITS  = 8,
   parameter int unsigned P_SIF_RD_WR_BITS = 1,
   parameter int unsigned P_SYNC_STAGES    = 2
) (
   input  logic                       i_clk,
   input  logic                       i_arst_n,
   input  logic                       i_sclk,
   input  logic                       i_sel_n,
   input  logic                       i_sdin,
   output logic                       o_sdout,
   output logic                       o_sdout_oe,
   output logic                       o_wr_valid,
   output logic [P_SIF_ADDR_BITS-1:0] o_wr_addr,
   output logic [P_SIF_DATA_BITS-1:0] o_wr_data,
   output logic                       o_rd_req,
   output logic [P_SIF_ADDR_BITS-1:0] o_rd_addr,
   input  logic [P_SIF_DATA_BITS-1:0] i_rd_data,
   output logic                       o_frame_err
);

   localparam int unsigned N      = sif_frame_len(P_SIF_RD_WR_BITS, P_SIF_ADDR_BITS, P_SIF_DATA_BITS);
   localparam int unsigned CW     = $clog2(N) + 1;
   localparam int unsigned HL     = P_SIF_RD_WR_BITS + P_SIF_ADDR_BITS;
   localparam int unsigned FW     = P_SIF_ADDR_BITS + P_SIF_DATA_BITS;
   localparam int unsigned SETTLE = P_SYNC_STAGES + 1;
   localparam int unsigned SW     = $clog2(P_SYNC_STAGES + 2);

   if (P_SIF_RD_WR_BITS > 1) begin : g_bad_rw
      $fatal(1, "ti_sif_rx: P_SIF_RD_WR_BITS must be 0 or 1");
   end
   if (P_SYNC_STAGES < 2) begin : g_bad_sync
      $fatal(1, "ti_sif_rx: P_SYNC_STAGES must be at least 2");
   end

   logic sclk_rise, sclk_fall, sclk_lvl_unused;
   logic sel_lvl, sel_rise, sel_fall;
   logic sdin_lvl, sdin_rise_unused, sdin_fall_unused;

   ti_sif_sync #(.P_STAGES(P_SYNC_STAGES), .P_RST_VAL(1'b0)) u_sync_sclk (
      .i_clk(i_clk), .i_arst_n(i_arst_n), .i_d(i_sclk),
      .o_lvl(sclk_lvl_unused), .o_rise(sclk_rise), .o_fall(sclk_fall));

   ti_sif_sync #(.P_STAGES(P_SYNC_STAGES), .P_RST_VAL(1'b1)) u_sync_sel (
      .i_clk(i_clk), .i_arst_n(i_arst_n), .i_d(i_sel_n),
      .o_lvl(sel_lvl), .o_rise(sel_rise), .o_fall(sel_fall));

   ti_sif_sync #(.P_STAGES(P_SYNC_STAGES), .P_RST_VAL(1'b0)) u_sync_sdin (
      .i_clk(i_clk), .i_arst_n(i_arst_n), .i_d(i_sdin),
      .o_lvl(sdin_lvl), .o_rise(sdin_rise_unused), .o_fall(sdin_fall_unused));

   sif_state_e    state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [FW-1:0] frm;
   logic [FW-1:0] frm_nxt;
   logic [SW-1:0] settle;
   logic          rd_rej;

   // Saturating bit count and frame shift; the R/W bit falls off the top.
   assign cnt_nxt = (cnt == CW'(N + 1)) ? cnt : cnt + CW'(1);
   assign frm_nxt = {frm[FW-2:0], sdin_lvl};

`ifdef TI_SIF_RX_RD_EN
   logic [P_SIF_DATA_BITS-1:0] rd_sh;
`else
   logic unused_rd;
   assign unused_rd  = ^{i_rd_data, sclk_fall};
   assign o_rd_req   = 1'b0;
   assign o_rd_addr  = '0;
   assign o_sdout    = 1'b0;
   assign o_sdout_oe = 1'b0;
`endif

   // Frame FSM: deselect always ends a frame; WAIT_DESEL lets the sel_n
   // synchronizer settle so a frame cut by reset is discarded.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state       <= ST_WAIT_DESEL;
         cnt         <= '0;
         frm         <= '0;
         settle      <= '0;
         rd_rej      <= 1'b0;
         o_wr_valid  <= 1'b0;
         o_wr_addr   <= '0;
         o_wr_data   <= '0;
         o_frame_err <= 1'b0;
`ifdef TI_SIF_RX_RD_EN
         o_rd_req    <= 1'b0;
         o_rd_addr   <= '0;
         o_sdout     <= 1'b0;
         o_sdout_oe  <= 1'b0;
         rd_sh       <= '0;
`endif
      end else begin
         o_wr_valid  <= 1'b0;
         o_frame_err <= 1'b0;
`ifdef TI_SIF_RX_RD_EN
         o_rd_req    <= 1'b0;
`endif
         if (sel_rise) begin
            state  <= ST_IDLE;
            rd_rej <= 1'b0;
`ifdef TI_SIF_RX_RD_EN
            o_sdout_oe <= 1'b0;
`endif
            if (state == ST_WAIT_DESEL) begin
               o_frame_err <= rd_rej;
            end else if (state != ST_IDLE && cnt != '0) begin
               if (cnt != CW'(N)) begin
                  o_frame_err <= 1'b1;
               end else if (state == ST_WDATA) begin
                  o_wr_valid <= 1'b1;
                  o_wr_addr  <= frm[P_SIF_DATA_BITS +: P_SIF_ADDR_BITS];
                  o_wr_data  <= frm[P_SIF_DATA_BITS-1:0];
               end
            end
         end else begin
            case (state)
               ST_IDLE: begin
                  if (sel_fall) begin
                     cnt   <= '0;
                     state <= ST_HDR;
                  end
               end
               ST_HDR: begin
                  if (sclk_rise) begin
                     frm <= frm_nxt;
                     cnt <= cnt_nxt;
                     if (cnt_nxt == CW'(HL)) begin
                        if (P_SIF_RD_WR_BITS == 0 || !frm_nxt[P_SIF_ADDR_BITS]) begin
                           state <= ST_WDATA;
                        end else begin
`ifdef TI_SIF_RX_RD_EN
                           o_rd_req   <= 1'b1;
                           o_rd_addr  <= frm_nxt[P_SIF_ADDR_BITS-1:0];
                           o_sdout_oe <= 1'b1;
                           state      <= ST_RDATA;
`else
                           rd_rej <= 1'b1;
                           settle <= '0;
                           state  <= ST_WAIT_DESEL;
`endif
                        end
                     end
                  end
               end
               ST_WDATA: begin
                  if (sclk_rise) begin
                     frm <= frm_nxt;
                     cnt <= cnt_nxt;
                  end
               end
`ifdef TI_SIF_RX_RD_EN
               ST_RDATA: begin
                  if (o_rd_req) begin
                     rd_sh <= i_rd_data;
                  end
                  if (sclk_rise) begin
                     cnt <= cnt_nxt;
                  end
                  if (sclk_fall) begin
                     o_sdout <= rd_sh[P_SIF_DATA_BITS-1];
                     rd_sh   <= rd_sh << 1;
                  end
               end
`endif
               ST_WAIT_DESEL: begin
                  if (settle != SW'(SETTLE)) begin
                     settle <= settle + SW'(1);
                  end else if (sel_lvl) begin
                     state <= ST_IDLE;
                  end
               end
               default: begin
                  state <= ST_WAIT_DESEL;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ti_sif_rx.sv
// Self-checking bench for ti_sif_rx (default parameters). Frames are driven
// at the pins; a scoreboard compares every strobe/error/read-request pulse
// against expectations computed from the frame contents.
`timescale 1ns/1ps
module tb_ti_sif_rx;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int RW = 1;
   localparam int SS = 2;
   localparam int N  = RW + AW + DW;

   logic          i_clk = 1'b0;
   logic          i_arst_n;
   logic          i_sclk;
   logic          i_sel_n;
   logic          i_sdin;
   logic          o_sdout;
   logic          o_sdout_oe;
   logic          o_wr_valid;
   logic [AW-1:0] o_wr_addr;
   logic [DW-1:0] o_wr_data;
   logic          o_rd_req;
   logic [AW-1:0] o_rd_addr;
   logic [DW-1:0] i_rd_data;
   logic          o_frame_err;

   int checks = 0;
   int errors = 0;

   // expected event queue: kind 0 = write, 1 = frame error, 2 = read request
   int         exp_kind[$];
   logic [7:0] exp_a[$];
   logic [7:0] exp_d[$];

   typedef struct {
      logic [31:0] word;
      int          len;
      int          gap;
      int          rst_at;
      logic [7:0]  rd_data;
   } vec_t;

   vec_t vecs[$];

   ti_sif_rx #(
      .P_SIF_ADDR_BITS(AW), .P_SIF_DATA_BITS(DW),
      .P_SIF_RD_WR_BITS(RW), .P_SYNC_STAGES(SS)
   ) dut (
      .i_clk(i_clk), .i_arst_n(i_arst_n), .i_sclk(i_sclk), .i_sel_n(i_sel_n),
      .i_sdin(i_sdin), .o_sdout(o_sdout), .o_sdout_oe(o_sdout_oe),
      .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
      .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
      .o_frame_err(o_frame_err));

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int kind, input logic [7:0] a, input logic [7:0] d);
      exp_kind.push_back(kind);
      exp_a.push_back(a);
      exp_d.push_back(d);
   endtask

   // Reference: what the slave must report for a frame of len bits (MSB first).
   task automatic model_frame(input logic [31:0] w, input int len);
      bit is_rd;
      is_rd = (len >= RW + AW) && w[len-1];
      if (len == 0) return;
      if (is_rd) begin
`ifdef TI_SIF_RX_RD_EN
         push_exp(2, w[len-2 -: 8], 8'h00);
         if (len != N) push_exp(1, 8'h00, 8'h00);
`else
         push_exp(1, 8'h00, 8'h00);
`endif
      end else if (len == N) begin
         push_exp(0, w[15:8], w[7:0]);
      end else begin
         push_exp(1, 8'h00, 8'h00);
      end
   endtask

   task automatic sb_event(input int kind, input logic [7:0] a, input logic [7:0] d);
      int         ek;
      logic [7:0] ea;
      logic [7:0] ed;
      if (exp_kind.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_unexpected kind=%0d addr=%h data=%h required=none at %0t", kind, a, d, $time);
      end else begin
         ek = exp_kind.pop_front();
         ea = exp_a.pop_front();
         ed = exp_d.pop_front();
         chk("sb_kind", 32'(kind), 32'(ek));
         if (kind == 0 && ek == 0) begin
            chk("sb_wr_addr", 32'(a), 32'(ea));
            chk("sb_wr_data", 32'(d), 32'(ed));
         end
         if (kind == 2 && ek == 2) chk("sb_rd_addr", 32'(a), 32'(ea));
      end
   endtask

   // Output monitor feeding the scoreboard, sampled away from the active edge.
   always @(negedge i_clk) begin
      if (i_arst_n) begin
         if (o_wr_valid)  sb_event(0, o_wr_addr, o_wr_data);
         if (o_frame_err) sb_event(1, 8'h00, 8'h00);
         if (o_rd_req)    sb_event(2, o_rd_addr, 8'h00);
      end
   end

   // Drive one frame: sclk period 8 i_clk, data set on sclk low, sampled on rise.
   // Optionally pulse reset before bit rst_at. Returns write latency (cycles
   // from sel_n rising at the pin to o_wr_valid) or 0 if none in the gap.
   task automatic send_frame(input logic [31:0] w, input int len, input int gap,
                             input int rst_at, input logic [7:0] rdd, output int lat);
      bit is_rd;
      is_rd = (len >= RW + AW) && w[len-1];
      lat = 0;
      i_rd_data = rdd;
      @(negedge i_clk);
      i_sel_n = 1'b0;
      repeat (4) @(negedge i_clk);
      for (int p = 0; p < len; p++) begin
         if (p == rst_at) begin
            i_arst_n = 1'b0;
            #1;
            chk("rst_wr_valid", 32'(o_wr_valid), 32'd0);
            chk("rst_wr_addr", 32'(o_wr_addr), 32'd0);
            chk("rst_wr_data", 32'(o_wr_data), 32'd0);
            chk("rst_frame_err", 32'(o_frame_err), 32'd0);
            repeat (2) @(negedge i_clk);
            i_arst_n = 1'b1;
         end
         i_sclk = 1'b0;
         i_sdin = w[len-1-p];
         repeat (4) @(negedge i_clk);
         i_sclk = 1'b1;
         repeat (4) @(negedge i_clk);
         if (is_rd && rst_at < 0 && p >= RW + AW && p < N) begin
`ifdef TI_SIF_RX_RD_EN
            chk("sdout_oe", 32'(o_sdout_oe), 32'd1);
            chk("sdout_bit", 32'(o_sdout), 32'(rdd[N-1-p]));
`else
            chk("sdout_oe_off", 32'(o_sdout_oe), 32'd0);
            chk("sdout_off", 32'(o_sdout), 32'd0);
`endif
         end
      end
      i_sclk = 1'b0;
      repeat (4) @(negedge i_clk);
      i_sel_n = 1'b1;
      for (int i = 1; i <= gap; i++) begin
         @(posedge i_clk);
         #1;
         if (o_wr_valid && lat == 0) lat = i;
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [31:0] w;
      int          len;
      int          r;

      i_arst_n  = 1'b0;
      i_sclk    = 1'b0;
      i_sel_n   = 1'b1;
      i_sdin    = 1'b0;
      i_rd_data = '0;
      repeat (3) @(negedge i_clk);
      chk("reset_wr_valid", 32'(o_wr_valid), 32'd0);
      chk("reset_wr_addr", 32'(o_wr_addr), 32'd0);
      chk("reset_wr_data", 32'(o_wr_data), 32'd0);
      chk("reset_frame_err", 32'(o_frame_err), 32'd0);
      chk("reset_rd_req", 32'(o_rd_req), 32'd0);
      chk("reset_sdout", 32'(o_sdout), 32'd0);
      chk("reset_sdout_oe", 32'(o_sdout_oe), 32'd0);
      i_arst_n = 1'b1;
      repeat (10) @(negedge i_clk);

      // directed table: {word, len, gap, rst_at, rd_data}
      vecs.push_back('{32'h05AC3, 17, 12, -1, 8'h00});  // write 0x5A <- 0xC3
      vecs.push_back('{32'h01234, 16, 12, -1, 8'h00});  // short frame
      vecs.push_back('{32'h2ABCD, 18, 12, -1, 8'h00});  // long frame
      vecs.push_back('{32'h11200, 17, 12, -1, 8'hA5});  // read 0x12
      vecs.push_back('{32'h00111, 17,  4, -1, 8'h00});  // back-to-back writes
      vecs.push_back('{32'h00222, 17,  4, -1, 8'h00});
      vecs.push_back('{32'h0FF00, 17, 12, -1, 8'h00});
      vecs.push_back('{32'h03C96, 17, 12,  9, 8'h00});  // reset mid-frame
      vecs.push_back('{32'h0A75E, 17, 12, -1, 8'h00});  // decodes after reset

      foreach (vecs[i]) begin
         if (vecs[i].rst_at < 0) model_frame(vecs[i].word, vecs[i].len);
         send_frame(vecs[i].word, vecs[i].len, vecs[i].gap, vecs[i].rst_at, vecs[i].rd_data, lat);
      end

      // write strobe latency and held address/data after the pulse
      model_frame(32'h04D6B, N);
      send_frame(32'h04D6B, N, 12, -1, 8'h00, lat);
      chk("wr_latency", 32'(lat), 32'(SS + 2));
      repeat (5) @(negedge i_clk);
      chk("wr_addr_held", 32'(o_wr_addr), 32'h4D);
      chk("wr_data_held", 32'(o_wr_data), 32'h6B);
      chk("wr_valid_low", 32'(o_wr_valid), 32'd0);

      // randomized frames against the reference model
      for (int t = 0; t < 24; t++) begin
         r = $urandom_range(0, 9);
         w = 32'($urandom);
         if (r <= 5)      len = N;
         else if (r == 6) len = N - 1;
         else if (r == 7) len = N + 1;
         else if (r == 8) len = $urandom_range(1, 20);
         else             len = N;
         w = w & ((32'd1 << len) - 32'd1);
         if (r == 9) w[N-1] = 1'b1;
         else if (r <= 5) w[N-1] = 1'b0;
         model_frame(w, len);
         send_frame(w, len, $urandom_range(4, 8), -1, 8'($urandom), lat);
      end

      repeat (20) @(negedge i_clk);
      chk("sb_drain", 32'(exp_kind.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ti_sif_rx.md
TI_SIF_RX -- requirements
Module: ti_sif_rx

Interface
REQ-001 SHALL have parameter P_SIF_ADDR_BITS, default 8, address field width.
REQ-002 SHALL have parameter P_SIF_DATA_BITS, default 8, data field width.
REQ-003 SHALL have parameter P_SIF_RD_WR_BITS, default 1, R/W flag width; legal values 0 or 1; fatal elaboration error otherwise.
REQ-004 SHALL have parameter P_SYNC_STAGES, default 2, synchronizer depth; fatal elaboration error if less than 2.
REQ-005 SHALL have port i_clk, input, 1, single block clock.
REQ-006 SHALL have port i_arst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports i_sclk, i_sel_n and i_sdin, inputs, 1 each, asynchronous SIF clock, select and serial data from the SIF master.
REQ-008 SHALL have ports o_sdout and o_sdout_oe, outputs, 1 each, read-data bit and its output enable.
REQ-009 SHALL have ports o_wr_valid (1), o_wr_addr (P_SIF_ADDR_BITS) and o_wr_data (P_SIF_DATA_BITS), outputs, register-write strobe, address and data.
REQ-010 SHALL have ports o_rd_req (1) and o_rd_addr (P_SIF_ADDR_BITS), outputs, register-read request and address.
REQ-011 SHALL have port i_rd_data, input, P_SIF_DATA_BITS, read data.
REQ-012 SHALL have port o_frame_err, output, 1, malformed-frame pulse.

Function
REQ-013 SHALL synchronize i_sclk, i_sel_n and i_sdin through P_SYNC_STAGES flops each, then register one more stage for edge detection.
REQ-014 SHALL require the i_clk frequency to be at least 8x the i_sclk frequency.
REQ-015 SHALL implement states IDLE, HDR, WDATA, RDATA and WAIT_DESEL.
REQ-016 IDLE: a synchronized falling edge of sel_n SHALL clear the bit counter and enter HDR.
REQ-017 SHALL sample sdin on each synchronized sclk rising edge while sel_n is low, MSB first; frame length N = P_SIF_RD_WR_BITS + P_SIF_ADDR_BITS + P_SIF_DATA_BITS.
REQ-018 HDR: after the last address bit, R/W=0 (or P_SIF_RD_WR_BITS=0) SHALL enter WDATA; R/W=1 SHALL behave as in REQ-027/028.
REQ-019 The bit counter SHALL be $clog2(N)+1 bits and saturate at N+1; it SHALL never wrap.
REQ-020 On a sel_n rising edge with count == N in WDATA, SHALL pulse o_wr_valid for exactly one i_clk, with o_wr_addr/o_wr_data valid and held until the next write.
REQ-021 o_wr_valid SHALL assert P_SYNC_STAGES+2 i_clk cycles after i_sel_n rises at the pin.
REQ-022 On a sel_n rising edge with 0 < count != N, SHALL pulse o_frame_err for one cycle, issue no write and return to IDLE.
REQ-023 On a sel_n rising edge with count == 0, SHALL return to IDLE silently.
REQ-024 Each sel_n rising edge SHALL return the block to IDLE from any state.
REQ-025 Back-to-back frames separated by sel_n high for at least 4 i_clk SHALL each be decoded.

Reset
REQ-026 On i_arst_n low, SHALL immediately clear all outputs and counters and enter WAIT_DESEL; synchronizer flops SHALL reset to idle levels (sclk=0, sel_n=1, sdin=0). WAIT_DESEL SHALL ignore all traffic until a synchronized sel_n high is seen, then enter IDLE, so a frame in progress at reset release is discarded.

Configuration
REQ-027 With TI_SIF_RX_RD_EN defined and P_SIF_RD_WR_BITS=1, an R/W=1 header SHALL pulse o_rd_req for one cycle with o_rd_addr, capture i_rd_data on the next i_clk, and enter RDATA; RDATA SHALL assert o_sdout_oe and drive each data bit, MSB first, on successive synchronized sclk falling edges, starting with the falling edge after the last address bit; o_sdout_oe SHALL drop on sel_n rising.
REQ-028 With TI_SIF_RX_RD_EN undefined, an R/W=1 header SHALL enter WAIT_DESEL and pulse o_frame_err on sel_n rising; o_rd_req, o_sdout and o_sdout_oe SHALL be tied to 0 and i_rd_data SHALL be unused.

Structure
REQ-029 Package ti_sif_pkg SHALL hold the FSM state enum and a frame-length function of the three width parameters.
REQ-030 Sub-module ti_sif_sync (parameterized synchronizer with rise/fall edge outputs) SHALL be instantiated once per SIF input.

Verification
REQ-031 Write of addr 0x5A, data 0xC3 (17 bits, R/W=0) -> one o_wr_valid pulse with o_wr_addr=0x5A, o_wr_data=0xC3, and o_frame_err=0.
REQ-032 A 16-bit frame, then an 18-bit frame -> one o_frame_err pulse each and no o_wr_valid.
REQ-033 Read of addr 0x12 with i_rd_data=0xA5 (RD_EN defined) -> o_rd_req pulse with o_rd_addr=0x12; o_sdout sequence 1,0,1,0,0,1,0,1 with o_sdout_oe=1; undefined -> o_frame_err pulse and o_sdout_oe stays 0.
REQ-034 i_arst_n pulsed after 9 bits, released while sel_n is low, remaining bits sent -> no strobe or error; the next full frame decodes correctly.
REQ-035 Three back-to-back writes (0x01/0x11, 0x02/0x22, 0xFF/0x00), 4-cycle sel_n gaps -> three o_wr_valid pulses in order with matching values.
